// File: rtl/mmio_pkg.sv
// Shared register-map offsets and CTRL layout for the GPIO/timer peripheral.
package mmio_pkg;

    localparam logic [4:0] OFS_LEDS      = 5'h00;
    localparam logic [4:0] OFS_SW        = 5'h04;
    localparam logic [4:0] OFS_SW_EDGE   = 5'h08;
    localparam logic [4:0] OFS_TMR_LOAD  = 5'h0C;
    localparam logic [4:0] OFS_TMR_COUNT = 5'h10;
    localparam logic [4:0] OFS_CTRL      = 5'h14;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_EXPIRED = 2;
    localparam int CTRL_IRQ_EN  = 3;

    // Field order matches the bit indices above (en is bit 0).
    typedef struct packed {
        logic irq_en;
        logic expired;
        logic auto_rl;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a per-bit hold counter; a level is accepted
// only after it differs from the current accepted level for DEBOUNCE_CYC edges.
module sw_debounce #(
    parameter int N_IO         = 10,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N_IO-1:0] i_raw,
    output logic [N_IO-1:0] o_level,
    output logic [N_IO-1:0] o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC);

    logic [N_IO-1:0] r_sync1;
    logic [N_IO-1:0] r_sync2;
    logic [N_IO-1:0] r_level;
    logic [CW-1:0]   r_cnt [N_IO];
    logic [N_IO-1:0] w_done;

    always_comb begin
        for (int i = 0; i < N_IO; i++) begin
            w_done[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CW'(DEBOUNCE_CYC - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_cnt   <= '{default: '0};
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_IO; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_done[i]) begin
                    r_cnt[i]   <= '0;
                    r_level[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rise pulse is valid in the cycle before the accepted level changes,
    // so the edge register captures it on the same clock edge.
    assign o_rise  = w_done & r_sync2;
    assign o_level = r_level;

endmodule

// File: rtl/mmio_gpio_timer.sv
// Memory-mapped LED/switch/timer responder sitting beside the data RAM;
// sel steers the data-memory read mux toward rdata.
module mmio_gpio_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0C00,
    parameter int          N_IO         = 10,
    parameter int          DEBOUNCE_CYC = 16,
    parameter int          PRESCALE     = 4
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            mem_write,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            sel,
    input  logic [N_IO-1:0] switches,
    output logic [N_IO-1:0] leds,
    output logic            timer_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [31:0]     w_word_addr;
    logic [31:0]     w_offset;
    logic [4:0]      w_ofs;
    logic            w_wr;
    logic [N_IO-1:0] w_sw_level;
    logic [N_IO-1:0] w_sw_rise;
    logic [N_IO-1:0] w_edge_clr;
    logic            w_wrap;
    logic            w_expire;

    logic [N_IO-1:0] r_leds;
    logic [N_IO-1:0] r_sw_edge;
    logic [31:0]     r_load;
    logic [31:0]     r_count;
    logic [PW-1:0]   r_pre;
    ctrl_t           r_ctrl;

    sw_debounce #(
        .N_IO         (N_IO),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_sw_debounce (
        .clk     (clk),
        .nreset  (nreset),
        .i_raw   (switches),
        .o_level (w_sw_level),
        .o_rise  (w_sw_rise)
    );

    always_comb begin
        w_word_addr = addr & ~32'h3;
        w_offset    = w_word_addr - BASE_ADDR;
        sel         = (w_word_addr >= BASE_ADDR) && (w_offset <= 32'h14);
        w_ofs       = w_offset[4:0];
        w_wr        = mem_write && sel;
        w_edge_clr  = (w_wr && w_ofs == OFS_SW_EDGE) ? wdata[N_IO-1:0] : '0;
        w_wrap      = r_ctrl.en && (r_pre == PW'(PRESCALE - 1));
        w_expire    = w_wrap && (r_count == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_leds    <= '0;
            r_sw_edge <= '0;
        end else begin
            if (w_wr && w_ofs == OFS_LEDS) r_leds <= wdata[N_IO-1:0];
            r_sw_edge <= (r_sw_edge & ~w_edge_clr) | w_sw_rise;
        end
    end

    // Later assignments in this block override earlier ones: software LOAD
    // writes beat the reload, and expiry beats a same-cycle EXPIRED clear.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_load  <= '0;
            r_count <= '0;
            r_pre   <= '0;
            r_ctrl  <= '0;
        end else begin
            if (r_ctrl.en) r_pre <= w_wrap ? '0 : r_pre + 1'b1;
            if (w_wrap) begin
                if (r_count != 32'd0)  r_count <= r_count - 32'd1;
                else if (r_ctrl.auto_rl) r_count <= r_load;
            end
            if (w_expire) begin
                r_ctrl.expired <= 1'b1;
                if (!r_ctrl.auto_rl) r_ctrl.en <= 1'b0;
            end
            if (w_wr && w_ofs == OFS_TMR_LOAD) begin
                r_load  <= wdata;
                r_count <= wdata;
                r_pre   <= '0;
            end
            if (w_wr && w_ofs == OFS_CTRL) begin
                r_ctrl.en     <= wdata[CTRL_EN];
                r_ctrl.auto_rl <= wdata[CTRL_AUTO];
                r_ctrl.irq_en <= wdata[CTRL_IRQ_EN];
                if (wdata[CTRL_EXPIRED] && !w_expire) r_ctrl.expired <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (w_ofs)
                OFS_LEDS:      rdata[N_IO-1:0] = r_leds;
                OFS_SW:        rdata[N_IO-1:0] = w_sw_level;
                OFS_SW_EDGE:   rdata[N_IO-1:0] = r_sw_edge;
                OFS_TMR_LOAD:  rdata           = r_load;
                OFS_TMR_COUNT: rdata           = r_count;
                OFS_CTRL:      rdata[3:0]      = r_ctrl;
                default:       rdata           = '0;
            endcase
        end
    end

    assign leds      = r_leds;
    assign timer_irq = r_ctrl.expired & r_ctrl.irq_en;

endmodule

// File: tb/tb_mmio_gpio_timer.sv
// Directed bench with a cycle-level behavioural model of the register map,
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_mmio_gpio_timer;

    localparam logic [31:0] BASE = 32'h0000_0C00;
    localparam int N_IO = 10;
    localparam int DEB  = 16;
    localparam int PRE  = 4;

    logic            clk = 1'b0;
    logic            nreset;
    logic            mem_write;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            sel;
    logic [N_IO-1:0] switches;
    logic [N_IO-1:0] leds;
    logic            timer_irq;

    always #5 clk = ~clk;

    mmio_gpio_timer #(
        .BASE_ADDR    (BASE),
        .N_IO         (N_IO),
        .DEBOUNCE_CYC (DEB),
        .PRESCALE     (PRE)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .sel       (sel),
        .switches  (switches),
        .leds      (leds),
        .timer_irq (timer_irq)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_valid = 0;
    logic [N_IO-1:0] m_leds, m_level, m_edge, m_raw0, m_raw1;
    logic [N_IO-1:0] m_hist[$];
    logic [31:0]     m_load, m_count;
    int              m_phase;
    bit              m_en, m_auto, m_exp, m_irqen;

    function automatic bit m_sel(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & ~32'h3;
        return (wa >= BASE) && (wa - BASE <= 32'd20);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (!m_sel(a)) return 32'd0;
        case (((a & ~32'h3) - BASE) >> 2)
            0: return {22'd0, m_leds};
            1: return {22'd0, m_level};
            2: return {22'd0, m_edge};
            3: return m_load;
            4: return m_count;
            5: return {28'd0, m_irqen, m_exp, m_auto, m_en};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [N_IO-1:0] s2, rise, nlev, clr;
        logic [31:0]     n_count;
        int              n_phase, ofs;
        bit              wr, all_diff, n_en, n_exp, expire;
        if (!nreset) begin
            m_valid = 1;
            m_leds = '0; m_level = '0; m_edge = '0; m_raw0 = '0; m_raw1 = '0;
            m_hist.delete();
            m_load = '0; m_count = '0; m_phase = 0;
            m_en = 0; m_auto = 0; m_exp = 0; m_irqen = 0;
        end else begin
            wr  = mem_write && m_sel(addr);
            ofs = int'(((addr & ~32'h3) - BASE) >> 2);
            // Accept a bit once the last DEB synchronized samples all disagree with it.
            s2 = m_raw1;
            m_hist.push_back(s2);
            if (m_hist.size() > DEB) m_hist.delete(0);
            rise = '0;
            nlev = m_level;
            if (m_hist.size() == DEB) begin
                for (int b = 0; b < N_IO; b++) begin
                    all_diff = 1;
                    foreach (m_hist[k]) if (m_hist[k][b] == m_level[b]) all_diff = 0;
                    if (all_diff) begin
                        nlev[b] = ~m_level[b];
                        rise[b] = ~m_level[b];
                    end
                end
            end
            m_raw1 = m_raw0;
            m_raw0 = switches;
            clr = (wr && ofs == 2) ? wdata[N_IO-1:0] : '0;
            m_edge  = (m_edge & ~clr) | rise;
            m_level = nlev;
            if (wr && ofs == 0) m_leds = wdata[N_IO-1:0];
            // Timer: one tick every PRE enabled cycles.
            n_count = m_count; n_phase = m_phase; n_en = m_en; n_exp = m_exp; expire = 0;
            if (m_en) begin
                n_phase = (m_phase + 1) % PRE;
                if (n_phase == 0) begin
                    if (m_count > 0) n_count = m_count - 1;
                    else begin
                        expire = 1;
                        n_exp = 1;
                        if (m_auto) n_count = m_load; else n_en = 0;
                    end
                end
            end
            if (wr && ofs == 3) begin
                m_load = wdata; n_count = wdata; n_phase = 0;
            end
            if (wr && ofs == 5) begin
                n_en = wdata[0]; m_auto = wdata[1]; m_irqen = wdata[3];
                if (wdata[2] && !expire) n_exp = 0;
            end
            m_count = n_count; m_phase = n_phase; m_en = n_en; m_exp = n_exp;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("leds", {22'd0, leds}, {22'd0, m_leds});
            check("timer_irq", {31'd0, timer_irq}, {31'd0, m_exp & m_irqen});
            check("sel", {31'd0, sel}, {31'd0, m_sel(addr)});
            check("rdata", rdata, m_rdata(addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        mem_write = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        addr = a;
        #1;
        check(nm, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        nreset = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; switches = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_leds", {22'd0, leds}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        rd(32'hC04, 32'd0, "rst_sw");
        rd(32'hC14, 32'd0, "rst_ctrl");
        switches = '0;
        nreset = 1'b1;

        wr(32'hC00, 32'hFFFF_F2A5);
        check("led_wr", {22'd0, leds}, 32'h2A5);
        rd(32'hC00, 32'h2A5, "led_rd");

        // Glitch shorter than the debounce window.
        @(posedge clk); #1 switches = 10'h008;
        repeat (5) @(posedge clk);
        #1 switches = 10'h000;
        repeat (30) @(posedge clk);
        #1;
        rd(32'hC04, 32'd0, "glitch_sw");
        rd(32'hC08, 32'd0, "glitch_edge");

        // Held level: accepted exactly DEB+2 edges later.
        @(posedge clk); #1 switches = 10'h008; addr = 32'hC04;
        for (int k = 1; k <= DEB + 2; k++) begin
            @(posedge clk); #1;
            check("sw_latency", rdata, (k >= DEB + 2) ? 32'h8 : 32'h0);
        end
        repeat (12) @(posedge clk);
        #1;
        rd(32'hC08, 32'h8, "sw_edge_set");
        wr(32'hC08, 32'h8);
        rd(32'hC08, 32'h0, "sw_edge_w1c");
        rd(32'hC04, 32'h8, "sw_level_hold");

        // One-shot timer.
        wr(32'hC0C, 32'd3);
        rd(32'hC10, 32'd3, "load_to_count");
        wr(32'hC14, 32'h9);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check("oneshot_irq", {31'd0, timer_irq}, (k == 16) ? 32'd1 : 32'd0);
        end
        rd(32'hC14, 32'hC, "oneshot_ctrl");
        rd(32'hC10, 32'd0, "oneshot_count");
        wr(32'hC14, 32'h4);
        rd(32'hC14, 32'h0, "ctrl_clear");

        // Auto-reload with a W1C colliding with the second expiry.
        wr(32'hC0C, 32'd2);
        wr(32'hC14, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check("auto_irq1", {31'd0, timer_irq}, (k == 12) ? 32'd1 : 32'd0);
        end
        wr(32'hC14, 32'hF);
        rd(32'hC14, 32'hB, "auto_w1c");
        repeat (8) @(posedge clk);
        wr(32'hC14, 32'hF);
        rd(32'hC14, 32'hF, "auto_set_wins");
        check("auto_irq2", {31'd0, timer_irq}, 32'd1);
        rd(32'hC10, 32'd2, "auto_reload");
        wr(32'hC14, 32'h4);
        rd(32'hC14, 32'h0, "auto_stop");

        // Decode boundaries.
        wr(32'hC18, 32'hFFFF_FFFF);
        check("dec_hi_sel", {31'd0, sel}, 32'd0);
        check("dec_hi_rd", rdata, 32'd0);
        wr(32'hBFC, 32'hFFFF_FFFF);
        check("dec_lo_sel", {31'd0, sel}, 32'd0);
        check("dec_lo_rd", rdata, 32'd0);
        rd(32'hC00, 32'h2A5, "dec_leds");
        rd(32'hC0C, 32'd2, "dec_load");
        rd(32'hC17, 32'h0, "dec_top_word");
        check("dec_top_sel", {31'd0, sel}, 32'd1);

        // Reset in the middle of counting.
        wr(32'hC0C, 32'd5);
        wr(32'hC14, 32'h1);
        repeat (3) @(posedge clk);
        #1 nreset = 1'b0;
        @(posedge clk); #1 nreset = 1'b1;
        rd(32'hC10, 32'd0, "midrst_count");
        rd(32'hC0C, 32'd0, "midrst_load");
        rd(32'hC14, 32'd0, "midrst_ctrl");
        rd(32'hC04, 32'd0, "midrst_sw");
        check("midrst_leds", {22'd0, leds}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
